// File: rtl/prog_interval_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : prog_interval_timer
// Description : Programmable interval timer. A prescaler divides clk down to
//               a TICK_HZ strobe (DIV = CLK_HZ/TICK_HZ, DIV >= 1), and a
//               WIDTH-bit counter steps once per strobe in one of three modes:
//                 mode 00 UP         : 0,1,2,... wraps, never expires
//                 mode 01 DOWN       : load,load-1,...,0 then expires
//                 mode 10 ONESHOT_UP : 0,1,...,load then expires
//                 mode 11            : same as UP
//               mode/load are captured on the start edge.
// Ports       : clk        clock
//               rst        asynchronous active-high reset
//               t_en       start level; its rising edge starts a run
//               t_stop     synchronous stop (RUN -> DONE, count frozen)
//               t_clear    synchronous clear (any state -> IDLE, count 0)
//               mode[1:0]  counting mode, sampled at start
//               load       DOWN start value / ONESHOT_UP target
//               t_valid    one-clk pulse whenever t_out takes a new value
//               t_out      current count
//               t_busy     high while running
//               t_expired  one-clk pulse when DOWN hits 0 / ONESHOT hits load
// Config      : define TIMER_SATURATE_EN to make UP counting hold at the
//               all-ones value instead of wrapping (no t_valid while held).
// Revision    : 1.0  initial release
// ============================================================================
module prog_interval_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_en,
  input  logic             t_stop,
  input  logic             t_clear,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load,
  output logic             t_valid,
  output logic [WIDTH-1:0] t_out,
  output logic             t_busy,
  output logic             t_expired
);

  localparam int               c_DIV      = CLK_HZ / TICK_HZ;
  localparam int               c_PW       = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_PW-1:0]  c_PRE_LAST = c_PW'(c_DIV - 1);
  localparam logic [c_PW-1:0]  c_PRE_ONE  = c_PW'(1);
  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

  localparam logic [1:0] c_MODE_UP      = 2'd0;
  localparam logic [1:0] c_MODE_DOWN    = 2'd1;
  localparam logic [1:0] c_MODE_ONESHOT = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [c_PW-1:0]  r_presc;
  logic [WIDTH-1:0] r_count;
  logic             r_valid;
  logic             r_expired;
  logic             r_en_d;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_load;

  logic             w_start;
  logic             w_tick;
  logic             w_zero_target;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;

  assign w_start = t_en & ~r_en_d;
  assign w_tick  = (r_state == S_RUN) && (r_presc == c_PRE_LAST);
  // DOWN from 0 or ONESHOT to 0 is already at its end value when started;
  // it expires on the first RUN cycle without emitting another value.
  assign w_zero_target = (r_mode != c_MODE_UP) && (r_load == '0);
  assign w_inc = r_count + c_ONE;
  assign w_dec = r_count - c_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_expired <= 1'b0;
      r_en_d    <= 1'b0;
      r_mode    <= c_MODE_UP;
      r_load    <= '0;
    end else begin
      r_en_d    <= t_en;
      r_valid   <= 1'b0;
      r_expired <= 1'b0;
      if (t_clear) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_presc <= '0;
      end else if (t_stop) begin
        // Stop only acts on a running timer; it also masks a start edge.
        if (r_state == S_RUN) begin
          r_state <= S_DONE;
          r_presc <= '0;
        end
      end else if (r_state == S_RUN) begin
        if (w_zero_target) begin
          r_state   <= S_DONE;
          r_expired <= 1'b1;
          r_presc   <= '0;
        end else if (w_tick) begin
          r_presc <= '0;
          case (r_mode)
            c_MODE_DOWN: begin
              r_count <= w_dec;
              r_valid <= 1'b1;
              if (w_dec == '0) begin
                r_state   <= S_DONE;
                r_expired <= 1'b1;
              end
            end
            c_MODE_ONESHOT: begin
              r_count <= w_inc;
              r_valid <= 1'b1;
              if (w_inc == r_load) begin
                r_state   <= S_DONE;
                r_expired <= 1'b1;
              end
            end
            default: begin
`ifdef TIMER_SATURATE_EN
              if (r_count != '1) begin
                r_count <= w_inc;
                r_valid <= 1'b1;
              end
`else
              r_count <= w_inc;
              r_valid <= 1'b1;
`endif
            end
          endcase
        end else begin
          r_presc <= r_presc + c_PRE_ONE;
        end
      end else if (w_start) begin
        // From IDLE or DONE: capture a fresh mode/load and publish the
        // initial value immediately.
        r_state <= S_RUN;
        r_presc <= '0;
        r_valid <= 1'b1;
        r_mode  <= (mode == 2'b11) ? c_MODE_UP : mode;
        r_load  <= load;
        r_count <= (mode == c_MODE_DOWN) ? load : '0;
      end
    end
  end

  assign t_valid   = r_valid;
  assign t_out     = r_count;
  assign t_busy    = (r_state == S_RUN);
  assign t_expired = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_prog_interval_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prog_interval_timer
// Description : Scoreboard bench for prog_interval_timer (CLK_HZ=40,
//               TICK_HZ=10 -> DIV=4, WIDTH=4). Each run computes its expected
//               output events from the counting rules and queues them; a
//               monitor pops and compares on every t_valid/t_expired.
// Revision    : 1.0  initial release
// ============================================================================
module tb_prog_interval_timer;

  localparam int c_CLK_HZ  = 40;
  localparam int c_TICK_HZ = 10;
  localparam int c_DIV     = c_CLK_HZ / c_TICK_HZ;
  localparam int c_W       = 4;

  logic           clk;
  logic           rst;
  logic           t_en;
  logic           t_stop;
  logic           t_clear;
  logic [1:0]     mode;
  logic [c_W-1:0] load;
  logic           t_valid;
  logic [c_W-1:0] t_out;
  logic           t_busy;
  logic           t_expired;

  prog_interval_timer #(
    .CLK_HZ (c_CLK_HZ),
    .TICK_HZ(c_TICK_HZ),
    .WIDTH  (c_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t_en     (t_en),
    .t_stop   (t_stop),
    .t_clear  (t_clear),
    .mode     (mode),
    .load     (load),
    .t_valid  (t_valid),
    .t_out    (t_out),
    .t_busy   (t_busy),
    .t_expired(t_expired)
  );

  typedef struct {
    int             cyc;
    logic [c_W-1:0] val;
    bit             vld;
    bit             exp;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT output event must match the head of the queue.
  always @(negedge clk) begin
    if (t_valid || t_expired) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected cyc=%0d got val=%0d vld=%0b exp=%0b required no event",
                 cyc, t_out, t_valid, t_expired);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.val != t_out ||
            mon_e.vld != t_valid || mon_e.exp != t_expired) begin
          fails++;
          $display("FAIL sb_event got cyc=%0d val=%0d vld=%0b exp=%0b required cyc=%0d val=%0d vld=%0b exp=%0b",
                   cyc, t_out, t_valid, t_expired, mon_e.cyc, mon_e.val, mon_e.vld, mon_e.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until posedge p has happened (sitting 1 time unit after it).
  task automatic goto(input int p);
    while (cyc < p) step();
  endtask

  task automatic chk(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  function automatic void push_ev(input int c, input int v, input bit vl, input bit ex);
    ev_t e;
    e.cyc = c;
    e.val = c_W'(v);
    e.vld = vl;
    e.exp = ex;
    q.push_back(e);
  endfunction

  // Reference model: events for a run starting (value loaded) at posedge s
  // and cut short by a stop/clear acting at posedge stop_at.
  task automatic model_run(input int m, input int ld, input int s,
                           input int stop_at, output int fin);
    int em;
    int v;
    em  = (m == 3) ? 0 : m;
    v   = (em == 1) ? ld : 0;
    fin = v;
    push_ev(s, v, 1'b1, 1'b0);
    if (em != 0 && ld == 0) begin
      if (s + 1 < stop_at) push_ev(s + 1, 0, 1'b0, 1'b1);
      return;
    end
    for (int k = 1; s + c_DIV * k < stop_at; k++) begin
      if (em == 0) begin
`ifdef TIMER_SATURATE_EN
        if (k <= 15) begin
          v = k;
          push_ev(s + c_DIV * k, v, 1'b1, 1'b0);
        end
`else
        v = k % 16;
        push_ev(s + c_DIV * k, v, 1'b1, 1'b0);
`endif
        fin = v;
      end else if (em == 1) begin
        v   = ld - k;
        fin = v;
        push_ev(s + c_DIV * k, v, 1'b1, v == 0);
        if (v == 0) break;
      end else begin
        v   = k;
        fin = v;
        push_ev(s + c_DIV * k, v, 1'b1, v == ld);
        if (v == ld) break;
      end
    end
  endtask

  // One run: fresh start edge, optional re-rise of t_en mid-run, then a
  // stop or clear pulse acting at posedge s + DIV*stop_ticks + d.
  task automatic do_run(input int m, input int ld, input int stop_ticks,
                        input int d, input bit use_clear, input bit retrig);
    int s;
    int stop_at;
    int fin;
    t_en = 1'b0;
    step();
    t_en    = 1'b1;
    mode    = 2'(m);
    load    = c_W'(ld);
    s       = cyc + 1;
    stop_at = s + c_DIV * stop_ticks + d;
    model_run(m, ld, s, stop_at, fin);
    goto(s);
    // Inputs sampled only at start; wiggle them during the run.
    mode = 2'($urandom_range(0, 3));
    load = c_W'($urandom_range(0, 15));
    if (retrig && (m == 0 || m == 3) && stop_at > s + 8) begin
      goto(s + 4);
      t_en = 1'b0;
      goto(s + 5);
      t_en = 1'b1;
    end
    goto(stop_at - 1);
    if (use_clear) t_clear = 1'b1;
    else           t_stop  = 1'b1;
    goto(stop_at);
    t_clear = 1'b0;
    t_stop  = 1'b0;
    chk("busy_after_end", int'(t_busy), 0);
    chk("out_after_end", int'(t_out), use_clear ? 0 : fin);
  endtask

  task automatic pulse_clear();
    t_clear = 1'b1;
    step();
    t_clear = 1'b0;
    chk("clear_out", int'(t_out), 0);
    chk("clear_busy", int'(t_busy), 0);
  endtask

  initial begin
    int s;
    int fin;
    rst     = 1'b1;
    t_en    = 1'b0;
    t_stop  = 1'b0;
    t_clear = 1'b0;
    mode    = 2'd0;
    load    = '0;
    step();
    step();
    chk("rst_out", int'(t_out), 0);
    chk("rst_valid", int'(t_valid), 0);
    chk("rst_busy", int'(t_busy), 0);
    chk("rst_expired", int'(t_expired), 0);
    #2 rst = 1'b0;
    step();

    // UP through a wrap, with a t_en re-rise mid-run that must be ignored.
    do_run(0, 0, 17, 2, 1'b0, 1'b1);
    pulse_clear();
    // DOWN load=3 ends naturally; later stop does nothing.
    do_run(1, 3, 6, 1, 1'b0, 1'b0);
    // ONESHOT_UP load=5, then restart from DONE.
    do_run(2, 5, 8, 1, 1'b0, 1'b0);
    do_run(2, 5, 7, 2, 1'b0, 1'b0);
    // Clear landing on the same clock as tick 2.
    do_run(0, 0, 2, 0, 1'b1, 1'b0);
    // Stop landing on the same clock as tick 3.
    do_run(0, 0, 3, 0, 1'b0, 1'b0);
    // Zero-load DOWN and ONESHOT.
    do_run(1, 0, 2, 1, 1'b0, 1'b0);
    do_run(2, 0, 1, 3, 1'b1, 1'b0);
    // Mode 11 behaves as UP; t_en held high for ~50 clocks.
    do_run(3, 7, 12, 3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a DOWN run at t_out=2.
    t_en = 1'b0;
    step();
    t_en = 1'b1;
    mode = 2'd1;
    load = 4'd3;
    s    = cyc + 1;
    model_run(1, 3, s, s + 6, fin);
    goto(s + 5);
    chk("pre_rst_out", int'(t_out), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", int'(t_out), 0);
    chk("arst_busy", int'(t_busy), 0);
    chk("arst_valid", int'(t_valid), 0);
    chk("arst_expired", int'(t_expired), 0);
    t_en = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    goto(cyc + 8);
    chk("post_rst_busy", int'(t_busy), 0);

    // Randomised runs.
    for (int i = 0; i < 12; i++) begin
      do_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(1, 20)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    goto(cyc + 10);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
